// File: rtl/sockit_spi_pkg.sv
// Shared types for the sockit SPI stream blocks.
package sockit_spi_pkg;

    // Default data type carried on all streams.
    typedef logic [31:0] dt_t;

    // Buffer occupancy for a 2-entry skid buffer (0..2).
    typedef logic [1:0] cnt_t;

    localparam cnt_t CNT_EMPTY = 2'd0;
    localparam cnt_t CNT_ONE   = 2'd1;
    localparam cnt_t CNT_FULL  = 2'd2;

endpackage

// File: rtl/sockit_spi_skid.sv
// Two-entry skid buffer. The output is fully registered, and the input ready
// depends only on the occupancy, so no combinational path runs from
// out_rdy_i to in_rdy_o.
module sockit_spi_skid
    import sockit_spi_pkg::*;
#(
    parameter type DT = dt_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_vld_i,
    output logic in_rdy_o,
    input  DT    in_dat_i,
    output logic out_vld_o,
    input  logic out_rdy_i,
    output DT    out_dat_o
);

    cnt_t cnt_q, cnt_d;
    DT    head_q, head_d;
    DT    tail_q, tail_d;
    logic wr, rd;

    assign in_rdy_o  = (cnt_q != CNT_FULL);
    assign out_vld_o = (cnt_q != CNT_EMPTY);
    assign out_dat_o = head_q;

    assign wr = in_vld_i & in_rdy_o;
    assign rd = out_vld_o & out_rdy_i;

    // Next-state for the occupancy count and the head/tail slots.
    // The head always holds the oldest entry, and the tail is used only at count 2.
    always_comb begin
        cnt_d  = cnt_q;
        head_d = head_q;
        tail_d = tail_q;
        case (cnt_q)
            CNT_EMPTY: begin
                if (wr) begin
                    head_d = in_dat_i;
                    cnt_d  = CNT_ONE;
                end
            end
            CNT_ONE: begin
                if (wr && rd) begin
                    head_d = in_dat_i;
                end else if (wr) begin
                    tail_d = in_dat_i;
                    cnt_d  = CNT_FULL;
                end else if (rd) begin
                    // head keeps stale data, which is don't-care while vld=0
                    cnt_d = CNT_EMPTY;
                end
            end
            CNT_FULL: begin
                if (rd) begin
                    head_d = tail_q;
                    cnt_d  = CNT_ONE;
                end
            end
            default: begin
                cnt_d = CNT_EMPTY;
            end
        endcase
    end

    // Buffer state register. Reset empties the buffer and clears the data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= CNT_EMPTY;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

endmodule

// File: rtl/sockit_spi_dmx.sv
// Registered 1:2 stream demultiplexer. sel steers each input transfer to
// so0 or so1. Each output has its own skid buffer, so a stalled consumer
// blocks only the inputs that sel steers to it.
module sockit_spi_dmx
    import sockit_spi_pkg::*;
#(
    parameter type DT    = dt_t,
    parameter int  DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sel,
    input  logic sti_vld_i,
    output logic sti_rdy_o,
    input  DT    sti_dat_i,
    output logic so0_vld_o,
    input  logic so0_rdy_i,
    output DT    so0_dat_o,
    output logic so1_vld_o,
    input  logic so1_rdy_i,
    output DT    so1_dat_o
);

    if (DEPTH != 2) begin : g_depth_chk
        $error("sockit_spi_dmx: DEPTH must be 2");
    end

    logic in0_vld, in1_vld;
    logic in0_rdy, in1_rdy;

    // The input is steered only to the selected buffer. Ready comes from that
    // buffer's fill state alone.
    assign in0_vld   = sti_vld_i & ~sel;
    assign in1_vld   = sti_vld_i &  sel;
    assign sti_rdy_o = sel ? in1_rdy : in0_rdy;

    sockit_spi_skid #(.DT(DT)) u_skid0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_vld_i  (in0_vld),
        .in_rdy_o  (in0_rdy),
        .in_dat_i  (sti_dat_i),
        .out_vld_o (so0_vld_o),
        .out_rdy_i (so0_rdy_i),
        .out_dat_o (so0_dat_o)
    );

    sockit_spi_skid #(.DT(DT)) u_skid1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_vld_i  (in1_vld),
        .in_rdy_o  (in1_rdy),
        .in_dat_i  (sti_dat_i),
        .out_vld_o (so1_vld_o),
        .out_rdy_i (so1_rdy_i),
        .out_dat_o (so1_dat_o)
    );

endmodule

// File: tb/tb_sockit_spi_dmx.sv
// Scoreboard bench for sockit_spi_dmx. The driver pushes every accepted input
// onto the queue of its selected output. The monitor checks that each output
// is valid exactly while its queue is non-empty, and that it presents the
// queue head. It pops the head when the output transfer completes.
module tb_sockit_spi_dmx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic        sti_vld_i;
    logic        sti_rdy_o;
    logic [31:0] sti_dat_i;
    logic        so0_vld_o, so0_rdy_i;
    logic [31:0] so0_dat_o;
    logic        so1_vld_o, so1_rdy_i;
    logic [31:0] so1_dat_o;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] q0[$];
    logic [31:0] q1[$];

    always #5 clk = ~clk;

    sockit_spi_dmx dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sel       (sel),
        .sti_vld_i (sti_vld_i),
        .sti_rdy_o (sti_rdy_o),
        .sti_dat_i (sti_dat_i),
        .so0_vld_o (so0_vld_o),
        .so0_rdy_i (so0_rdy_i),
        .so0_dat_o (so0_dat_o),
        .so1_vld_o (so1_vld_o),
        .so1_rdy_i (so1_rdy_i),
        .so1_dat_o (so1_dat_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Output monitor. It samples at the falling edge and pops at the rising
    // edge on which the output transfer completes.
    initial begin : monitor
        logic take0, take1;
        forever begin
            @(negedge clk);
            chk("so0_vld", 32'(so0_vld_o), 32'(q0.size() != 0));
            chk("so1_vld", 32'(so1_vld_o), 32'(q1.size() != 0));
            if (so0_vld_o && q0.size() != 0) chk("so0_dat", so0_dat_o, q0[0]);
            if (so1_vld_o && q1.size() != 0) chk("so1_dat", so1_dat_o, q1[0]);
            take0 = so0_vld_o & so0_rdy_i & rst_n;
            take1 = so1_vld_o & so1_rdy_i & rst_n;
            @(posedge clk);
            if (take0 && rst_n && q0.size() != 0) void'(q0.pop_front());
            if (take1 && rst_n && q1.size() != 0) void'(q1.pop_front());
        end
    end

    // One clock of driving. It checks the input ready against the model
    // occupancy and records an accepted input on its selected queue.
    task automatic tick(output logic acc);
        logic        s;
        logic [31:0] d;
        int          occ;
        @(negedge clk);
        s   = sel;
        d   = sti_dat_i;
        occ = s ? q1.size() : q0.size();
        if (rst_n) chk("sti_rdy", 32'(sti_rdy_o), 32'(occ < 2));
        acc = sti_vld_i & sti_rdy_o & rst_n;
        @(posedge clk);
        if (acc && rst_n) begin
            if (s) q1.push_back(d);
            else   q0.push_back(d);
        end
        #1;
    endtask

    task automatic idle(input int n);
        logic a;
        sti_vld_i = 1'b0;
        repeat (n) tick(a);
    endtask

    // Present one input and hold it until it is accepted, within a bounded wait.
    task automatic send(input logic s, input logic [31:0] d);
        logic a;
        int   k;
        sel       = s;
        sti_dat_i = d;
        sti_vld_i = 1'b1;
        a = 1'b0;
        k = 0;
        while (!a && k < 50) begin
            tick(a);
            k++;
        end
        if (!a) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: data 0x%0h not accepted within 50 cycles", d);
        end
        sti_vld_i = 1'b0;
    endtask

    initial begin : driver
        logic a;
        rst_n     = 1'b0;
        sel       = 1'b0;
        sti_vld_i = 1'b1;
        sti_dat_i = 32'h0BAD_0001;
        so0_rdy_i = 1'b1;
        so1_rdy_i = 1'b1;

        // The DUT is held in reset with the input valid, so no output may appear.
        #2;
        chk("rst_so0_dat", so0_dat_o, 32'h0);
        chk("rst_so1_dat", so1_dat_o, 32'h0);
        chk("rst_sti_rdy", 32'(sti_rdy_o), 32'h1);
        repeat (3) tick(a);
        rst_n = 1'b1;
        // The first edge after release takes the pending input.
        tick(a);
        chk("first_accept", 32'(a), 32'h1);
        sti_vld_i = 1'b0;
        idle(3);

        // Back-to-back streaming into so0.
        sel = 1'b0;
        send(1'b0, 32'h11);
        send(1'b0, 32'h22);
        send(1'b0, 32'h33);
        idle(3);

        // Back-pressure on so1. Two entries are accepted, then the input stalls.
        so1_rdy_i = 1'b0;
        send(1'b1, 32'hA0);
        send(1'b1, 32'hA1);
        sel = 1'b1; sti_dat_i = 32'hA2; sti_vld_i = 1'b1;
        tick(a);
        chk("bp_stall", 32'(a), 32'h0);

        // so1 stays full while so0 keeps accepting and draining.
        send(1'b0, 32'h55);
        idle(3);
        so1_rdy_i = 1'b1;
        send(1'b1, 32'hA2);
        idle(4);

        // Alternating sel with both consumers ready.
        send(1'b0, 32'd1);
        send(1'b1, 32'd2);
        send(1'b0, 32'd3);
        send(1'b1, 32'd4);
        idle(3);

        // Fill both buffers, then reset asynchronously between clock edges.
        so0_rdy_i = 1'b0;
        so1_rdy_i = 1'b0;
        send(1'b0, 32'hC0); send(1'b0, 32'hC1);
        send(1'b1, 32'hD0); send(1'b1, 32'hD1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_so0_vld", 32'(so0_vld_o), 32'h0);
        chk("async_so1_vld", 32'(so1_vld_o), 32'h0);
        q0.delete();
        q1.delete();
        so0_rdy_i = 1'b1;
        so1_rdy_i = 1'b1;
        idle(2);
        rst_n = 1'b1;
        idle(4);

        // Randomized traffic and back-pressure.
        for (int i = 0; i < 400; i++) begin
            sel       = 1'($urandom_range(1));
            sti_vld_i = ($urandom_range(3) != 0);
            sti_dat_i = $urandom;
            so0_rdy_i = ($urandom_range(2) != 0);
            so1_rdy_i = ($urandom_range(3) == 0);
            tick(a);
        end

        // Drain both outputs. Everything that was accepted must have come out.
        so0_rdy_i = 1'b1;
        so1_rdy_i = 1'b1;
        idle(6);
        chk("drain_q0", 32'(q0.size()), 32'h0);
        chk("drain_q1", 32'(q1.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
